// File: rtl/ecc_127_err_collect_if.sv
// Beat bus around ecc_127_err_collect: decoder-side input beat with error flags
// and consumer-side output beat. master = upstream/downstream environment, slave = the stage.
interface ecc_127_err_collect_if #(
  parameter int unsigned DATA_WIDTH = 127,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  in_vld;
  logic                  in_rdy;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  sbit_err;
  logic                  dbit_err;
  logic                  ecc_fault;
  logic                  out_vld;
  logic                  out_rdy;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  out_err;

  modport master (
    output in_vld, in_addr, data_in, sbit_err, dbit_err, ecc_fault, out_rdy,
    input  in_rdy, out_vld, data_out, out_err
  );

  modport slave (
    input  in_vld, in_addr, data_in, sbit_err, dbit_err, ecc_fault, out_rdy,
    output in_rdy, out_vld, data_out, out_err
  );
endinterface

// File: rtl/ecc_127_err_collect.sv
// ECC decoder output stage: 2-entry skid buffer, saturating error counters and sticky irq.
// Define ECC_ERR_FIRST_CAPT_EN to build the first-error capture registers.
module ecc_127_err_collect #(
  parameter int unsigned DATA_WIDTH = 127,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned SBIT_THR   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ecc_127_err_collect_if.slave  bus,
  input  logic                  clr_cnt,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
  output logic                  err_capt_vld,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [1:0]            first_err_type,
  output logic                  irq
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  // A threshold the counter can never represent is treated as disabled.
  localparam bit                   THR_EN  = (SBIT_THR != 0) && ((SBIT_THR >> CNT_WIDTH) == 0);
  localparam logic [CNT_WIDTH-1:0] THR_VAL = CNT_WIDTH'(SBIT_THR);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] base,
                                                   input logic                 hit);
    return (hit && (base != CNT_MAX)) ? base + CNT_WIDTH'(1) : base;
  endfunction

  logic                  rdy_q;
  logic                  m_vld, m_err, s_vld, s_err;
  logic [DATA_WIDTH-1:0] m_data, s_data;
  logic                  accept, m_free, beat_err;

  assign accept   = bus.in_vld & rdy_q;
  assign m_free   = ~m_vld | bus.out_rdy;
  assign beat_err = bus.dbit_err | bus.ecc_fault;

  // S is only ever filled while M is held, so M-free with S full never coincides with accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q  <= 1'b1;
      m_vld  <= 1'b0;
      m_err  <= 1'b0;
      m_data <= '0;
      s_vld  <= 1'b0;
      s_err  <= 1'b0;
      s_data <= '0;
    end else if (m_free) begin
      rdy_q <= 1'b1;
      if (s_vld) begin
        m_vld  <= 1'b1;
        m_data <= s_data;
        m_err  <= s_err;
        s_vld  <= 1'b0;
      end else if (accept) begin
        m_vld  <= 1'b1;
        m_data <= bus.data_in;
        m_err  <= beat_err;
      end else begin
        m_vld  <= 1'b0;
      end
    end else if (accept) begin
      s_vld  <= 1'b1;
      s_data <= bus.data_in;
      s_err  <= beat_err;
      rdy_q  <= 1'b0;
    end
  end

  assign bus.in_rdy   = rdy_q;
  assign bus.out_vld  = m_vld;
  assign bus.data_out = m_data;
  assign bus.out_err  = m_err;

  logic [CNT_WIDTH-1:0] sbit_q, dbit_q, fault_q;
  logic [CNT_WIDTH-1:0] sbit_nxt, dbit_nxt, fault_nxt;
  logic                 irq_q, irq_nxt, thr_hit;

  // clr_cnt wipes the old state first, so a colliding error beat counts as the first one.
  always_comb begin
    sbit_nxt  = sat_inc(clr_cnt ? '0 : sbit_q,  accept & bus.sbit_err);
    dbit_nxt  = sat_inc(clr_cnt ? '0 : dbit_q,  accept & bus.dbit_err);
    fault_nxt = sat_inc(clr_cnt ? '0 : fault_q, accept & bus.ecc_fault);
    thr_hit   = THR_EN && accept && bus.sbit_err && (sbit_nxt == THR_VAL);
    irq_nxt   = (irq_q & ~clr_cnt) | (accept & beat_err) | thr_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbit_q  <= '0;
      dbit_q  <= '0;
      fault_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      sbit_q  <= sbit_nxt;
      dbit_q  <= dbit_nxt;
      fault_q <= fault_nxt;
      irq_q   <= irq_nxt;
    end
  end

  assign sbit_cnt  = sbit_q;
  assign dbit_cnt  = dbit_q;
  assign fault_cnt = fault_q;
  assign irq       = irq_q;

`ifdef ECC_ERR_FIRST_CAPT_EN
  logic                  capt_vld_q;
  logic [ADDR_WIDTH-1:0] capt_addr_q;
  logic [1:0]            capt_type_q;
  logic                  any_err;

  assign any_err = bus.sbit_err | bus.dbit_err | bus.ecc_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      capt_vld_q  <= 1'b0;
      capt_addr_q <= '0;
      capt_type_q <= '0;
    end else begin
      if (clr_cnt) begin
        capt_vld_q  <= 1'b0;
        capt_addr_q <= '0;
        capt_type_q <= '0;
      end
      if (accept && any_err && (clr_cnt || !capt_vld_q)) begin
        capt_vld_q  <= 1'b1;
        capt_addr_q <= bus.in_addr;
        capt_type_q <= bus.ecc_fault ? 2'b11 : (bus.dbit_err ? 2'b10 : 2'b01);
      end
    end
  end

  assign err_capt_vld   = capt_vld_q;
  assign first_err_addr = capt_addr_q;
  assign first_err_type = capt_type_q;
`else
  logic unused_capt_addr;
  assign unused_capt_addr = ^bus.in_addr;

  assign err_capt_vld   = 1'b0;
  assign first_err_addr = '0;
  assign first_err_type = '0;
`endif

endmodule

// File: tb/tb_ecc_127_err_collect.sv
// Self-checking bench for ecc_127_err_collect: randomized and directed beats against a
// queue-based reference model; a second instance covers counter saturation.
`timescale 1ns/1ps
module tb_ecc_127_err_collect;

  localparam int unsigned DW      = 127;
  localparam int unsigned AW      = 8;
  localparam int unsigned CW      = 16;
  localparam int unsigned THR     = 16;
  localparam int unsigned CW2     = 4;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;
  localparam int unsigned SW      = 2 + DW + 1 + 3 * CW + 1 + AW + 2 + 1;
`ifdef ECC_ERR_FIRST_CAPT_EN
  localparam bit CAPT_EN = 1'b1;
`else
  localparam bit CAPT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_cnt, clr_cnt2;
  always #5 clk = ~clk;

  ecc_127_err_collect_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  ecc_127_err_collect_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

  logic [CW-1:0]  sbit_cnt, dbit_cnt, fault_cnt;
  logic           err_capt_vld, irq;
  logic [AW-1:0]  first_err_addr;
  logic [1:0]     first_err_type;
  logic [CW2-1:0] sbit_cnt2, dbit_cnt2, fault_cnt2;
  logic           err_capt_vld2, irq2;
  logic [AW-1:0]  first_err_addr2;
  logic [1:0]     first_err_type2;

  ecc_127_err_collect #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .SBIT_THR(THR)) dut (
    .clk(clk), .rst(rst), .bus(bus), .clr_cnt(clr_cnt),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt),
    .err_capt_vld(err_capt_vld), .first_err_addr(first_err_addr),
    .first_err_type(first_err_type), .irq(irq)
  );

  ecc_127_err_collect #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW2), .SBIT_THR(0)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus2), .clr_cnt(clr_cnt2),
    .sbit_cnt(sbit_cnt2), .dbit_cnt(dbit_cnt2), .fault_cnt(fault_cnt2),
    .err_capt_vld(err_capt_vld2), .first_err_addr(first_err_addr2),
    .first_err_type(first_err_type2), .irq(irq2)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: the buffer is a 2-deep FIFO, the rest are plain counters and flags.
  logic [DW:0]   q[$];
  int unsigned   m_sbit, m_dbit, m_fault;
  bit            m_irq, m_capt_vld;
  logic [AW-1:0] m_addr;
  logic [1:0]    m_type;

  function automatic void model_clear_errs();
    m_sbit = 0; m_dbit = 0; m_fault = 0;
    m_irq = 1'b0; m_capt_vld = 1'b0; m_addr = '0; m_type = '0;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  function automatic logic [SW-1:0] snap_model();
    logic          v, r, e, cv;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic [1:0]    t;
    v = (q.size() > 0);
    r = (q.size() < 2);
    d = '0; e = 1'b0;
    if (v) begin
      d = q[0][DW:1];
      e = q[0][0];
    end
    cv = CAPT_EN & m_capt_vld;
    a  = CAPT_EN ? m_addr : AW'(0);
    t  = CAPT_EN ? m_type : 2'b00;
    return {v, r, d, e, CW'(m_sbit), CW'(m_dbit), CW'(m_fault), cv, a, t, m_irq};
  endfunction

  // Stale data while the output is idle is not defined, so it is masked out.
  function automatic logic [SW-1:0] snap_dut();
    logic          v;
    logic [DW-1:0] d;
    logic          e;
    v = (q.size() > 0);
    d = v ? bus.data_out : DW'(0);
    e = v ? bus.out_err : 1'b0;
    return {bus.out_vld, bus.in_rdy, d, e, sbit_cnt, dbit_cnt, fault_cnt,
            err_capt_vld, first_err_addr, first_err_type, irq};
  endfunction

  task automatic drive_cycle(input logic vld, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic s, input logic d, input logic f,
                             input logic ordy, input logic clr);
    bit acc, pop;
    bus.in_vld = vld; bus.in_addr = addr; bus.data_in = data;
    bus.sbit_err = s; bus.dbit_err = d; bus.ecc_fault = f;
    bus.out_rdy = ordy; clr_cnt = clr;
    @(posedge clk);
    acc = vld && (q.size() < 2);
    pop = (q.size() > 0) && ordy;
    if (clr) model_clear_errs();
    if (acc) begin
      if (s && m_sbit < CNT_MAX) m_sbit++;
      if (d && m_dbit < CNT_MAX) m_dbit++;
      if (f && m_fault < CNT_MAX) m_fault++;
      if (d || f) m_irq = 1'b1;
      if (s && THR != 0 && m_sbit == THR) m_irq = 1'b1;
      if ((s || d || f) && !m_capt_vld) begin
        m_capt_vld = 1'b1;
        m_addr = addr;
        m_type = f ? 2'b11 : (d ? 2'b10 : 2'b01);
      end
    end
    if (pop) void'(q.pop_front());
    if (acc) q.push_back({data, d | f});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    q.delete();
    model_clear_errs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if ({bus.out_vld, bus.in_rdy, bus.out_err, irq} !== 4'b0100) begin
      fails++;
      $display("FAIL reset_flags: got vld/rdy/err/irq=%b expected 0100",
               {bus.out_vld, bus.in_rdy, bus.out_err, irq});
    end
    tests++;
    if (bus.data_out !== DW'(0)) begin
      fails++;
      $display("FAIL reset_data: got %h expected 0", bus.data_out);
    end
    tests++;
    if ({sbit_cnt, dbit_cnt, fault_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_cnt: got %h/%h/%h expected 0/0/0", sbit_cnt, dbit_cnt, fault_cnt);
    end
    tests++;
    if ({err_capt_vld, first_err_addr, first_err_type} !== '0) begin
      fails++;
      $display("FAIL reset_capt: got vld=%b addr=%h type=%b expected 0",
               err_capt_vld, first_err_addr, first_err_type);
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, AW'(i), DW'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tests++;
      if (bus.out_vld !== 1'b1 || bus.data_out !== DW'(i) || bus.in_rdy !== 1'b1) begin
        fails++;
        $display("FAIL stream_beat%0d: got vld=%b rdy=%b data=%h expected vld=1 rdy=1 data=%h",
                 i, bus.out_vld, bus.in_rdy, bus.data_out, DW'(i));
      end
    end
    idle(1);
    tests++;
    if ({sbit_cnt, dbit_cnt, fault_cnt, irq, bus.out_vld} !== '0) begin
      fails++;
      $display("FAIL stream_idle: got cnt=%h/%h/%h irq=%b vld=%b expected all 0",
               sbit_cnt, dbit_cnt, fault_cnt, irq, bus.out_vld);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a, b, c;
    logic [DW-1:0] exp_data[5];
    logic          exp_vld[5], exp_rdy[5];
    a = rand_data(); b = rand_data(); c = rand_data();
    exp_data = '{a, a, a, b, c};
    exp_vld  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    drive_cycle(1'b1, 8'h0A, a, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) drive_cycle(1'b1, 8'h0B, b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 2) drive_cycle(1'b1, 8'h0C, c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i >= 3) drive_cycle(1'b1, 8'h0C, c, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tests++;
      if (bus.out_vld !== exp_vld[i] || bus.in_rdy !== exp_rdy[i] || bus.data_out !== exp_data[i]) begin
        fails++;
        $display("FAIL bp_step%0d: got vld=%b rdy=%b data=%h expected vld=%b rdy=%b data=%h",
                 i, bus.out_vld, bus.in_rdy, bus.data_out, exp_vld[i], exp_rdy[i], exp_data[i]);
      end
      tests++;
      if (snap_dut() !== snap_model()) begin
        fails++;
        $display("FAIL bp_snap%0d: got %h expected %h", i, snap_dut(), snap_model());
      end
    end
    idle(1);
    tests++;
    if (bus.out_vld !== 1'b0 || bus.in_rdy !== 1'b1) begin
      fails++;
      $display("FAIL bp_drain: got vld=%b rdy=%b expected vld=0 rdy=1", bus.out_vld, bus.in_rdy);
    end
  endtask

  task automatic test_error_classes();
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive_cycle(1'b1, 8'h05, rand_data(), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tests++;
    if (irq !== 1'b0 || bus.out_err !== 1'b0) begin
      fails++;
      $display("FAIL err_sbit_beat: got irq=%b out_err=%b expected 0 0", irq, bus.out_err);
    end
    drive_cycle(1'b1, 8'h06, rand_data(), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tests++;
    if (irq !== 1'b1 || bus.out_err !== 1'b1) begin
      fails++;
      $display("FAIL err_dbit_beat: got irq=%b out_err=%b expected 1 1", irq, bus.out_err);
    end
    drive_cycle(1'b1, 8'h07, rand_data(), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tests++;
    if (bus.out_err !== 1'b1) begin
      fails++;
      $display("FAIL err_fault_beat: got out_err=%b expected 1", bus.out_err);
    end
    idle(1);
    tests++;
    if (sbit_cnt !== CW'(1) || dbit_cnt !== CW'(2) || fault_cnt !== CW'(1) || irq !== 1'b1) begin
      fails++;
      $display("FAIL err_counts: got %0d/%0d/%0d irq=%b expected 1/2/1 irq=1",
               sbit_cnt, dbit_cnt, fault_cnt, irq);
    end
    tests++;
    if ({err_capt_vld, first_err_addr, first_err_type} !==
        (CAPT_EN ? {1'b1, 8'h05, 2'b01} : 11'b0)) begin
      fails++;
      $display("FAIL err_capture: got vld=%b addr=%h type=%b expected capture-enabled=%b at 05/01",
               err_capt_vld, first_err_addr, first_err_type, CAPT_EN);
    end
    tests++;
    if (snap_dut() !== snap_model()) begin
      fails++;
      $display("FAIL err_snap: got %h expected %h", snap_dut(), snap_model());
    end
  endtask

  task automatic test_threshold();
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      drive_cycle(1'b1, AW'(8'h40 + i), rand_data(), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      if (i >= 15) begin
        tests++;
        if (sbit_cnt !== CW'(i) || irq !== (i == 16)) begin
          fails++;
          $display("FAIL thr_beat%0d: got sbit_cnt=%0d irq=%b expected %0d irq=%b",
                   i, sbit_cnt, irq, i, (i == 16));
        end
      end
    end
  endtask

  task automatic test_clear_collision();
    logic [DW-1:0] d;
    d = rand_data();
    drive_cycle(1'b1, 8'h33, rand_data(), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive_cycle(1'b1, 8'h2A, d, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tests++;
    if (sbit_cnt !== CW'(1) || dbit_cnt !== CW'(0) || fault_cnt !== CW'(0) || irq !== 1'b0) begin
      fails++;
      $display("FAIL clr_counts: got %0d/%0d/%0d irq=%b expected 1/0/0 irq=0",
               sbit_cnt, dbit_cnt, fault_cnt, irq);
    end
    tests++;
    if ({err_capt_vld, first_err_addr, first_err_type} !==
        (CAPT_EN ? {1'b1, 8'h2A, 2'b01} : 11'b0)) begin
      fails++;
      $display("FAIL clr_capture: got vld=%b addr=%h type=%b expected capture-enabled=%b at 2A/01",
               err_capt_vld, first_err_addr, first_err_type, CAPT_EN);
    end
    tests++;
    if (bus.out_vld !== 1'b1 || bus.data_out !== d) begin
      fails++;
      $display("FAIL clr_datapath: got vld=%b data=%h expected 1 %h", bus.out_vld, bus.data_out, d);
    end
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, 8'h11, rand_data(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h12, rand_data(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({bus.out_vld, bus.in_rdy, irq} !== 3'b010 || {sbit_cnt, dbit_cnt} !== '0) begin
      fails++;
      $display("FAIL rstmid_async: got vld=%b rdy=%b irq=%b cnt=%h/%h expected 0 1 0 0/0",
               bus.out_vld, bus.in_rdy, irq, sbit_cnt, dbit_cnt);
    end
    q.delete();
    model_clear_errs();
    bus.in_vld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    tests++;
    if (snap_dut() !== snap_model()) begin
      fails++;
      $display("FAIL rstmid_snap: got %h expected %h", snap_dut(), snap_model());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_cycle(($urandom % 4) != 0, AW'($urandom), rand_data(),
                  ($urandom % 6) == 0, ($urandom % 10) == 0, ($urandom % 14) == 0,
                  ($urandom % 3) != 0, ($urandom % 60) == 0);
      tests++;
      if (snap_dut() !== snap_model()) begin
        fails++;
        $display("FAIL rand_cycle%0d: got %h expected %h", i, snap_dut(), snap_model());
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 40; i++) begin
      bus2.in_vld = 1'b1; bus2.in_addr = AW'(i); bus2.data_in = rand_data();
      bus2.sbit_err = (i < 20); bus2.dbit_err = (i >= 20);
      @(posedge clk);
      @(negedge clk);
      if (i == 14 || i == 19 || i == 34 || i == 39) begin
        tests++;
        if (sbit_cnt2 !== CW2'(i < 20 ? (i < 15 ? i + 1 : 15) : 15) ||
            dbit_cnt2 !== CW2'(i < 20 ? 0 : (i < 35 ? i - 19 : 15)) ||
            irq2 !== (i >= 20) || bus2.in_rdy !== 1'b1) begin
          fails++;
          $display("FAIL sat_beat%0d: got sbit=%0d dbit=%0d irq=%b rdy=%b", i, sbit_cnt2, dbit_cnt2,
                   irq2, bus2.in_rdy);
        end
      end
    end
    bus2.in_vld = 1'b0;
  endtask

  initial begin
    bus.in_vld = 1'b0; bus.in_addr = '0; bus.data_in = '0; bus.sbit_err = 1'b0;
    bus.dbit_err = 1'b0; bus.ecc_fault = 1'b0; bus.out_rdy = 1'b1; clr_cnt = 1'b0;
    bus2.in_vld = 1'b0; bus2.in_addr = '0; bus2.data_in = '0; bus2.sbit_err = 1'b0;
    bus2.dbit_err = 1'b0; bus2.ecc_fault = 1'b0; bus2.out_rdy = 1'b1; clr_cnt2 = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_error_classes();
    test_threshold();
    test_clear_collision();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
